// File: rtl/counter_pkg.sv
// Shared constants and types for the modulo-N up/down counter.
package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } cnt_dir_e;

endpackage : counter_pkg

// File: rtl/counter_next_logic.sv
// Combinational next-count logic: load clamp, wrap/saturate at the range ends, terminal count.
module counter_next_logic
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_next,
    output logic             boundary_hit,
    output logic             tc
);

    // One extra bit so MODULUS == 2**WIDTH is representable and no compare relies on rollover
    localparam logic [WIDTH:0] MOD_V = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MODULUS - 1);

    cnt_dir_e       dir_s;
    logic [WIDTH:0] q_ext_s;
    logic [WIDTH:0] ld_ext_s;
    logic [WIDTH:0] inc_s;
    logic [WIDTH:0] dec_s;
    logic           at_max_s;
    logic           at_zero_s;

    assign dir_s     = cnt_dir_e'(up);
    assign q_ext_s   = {1'b0, q};
    assign ld_ext_s  = {1'b0, load_val};
    assign inc_s     = q_ext_s + {{WIDTH{1'b0}}, 1'b1};
    assign dec_s     = q_ext_s - {{WIDTH{1'b0}}, 1'b1};
    assign at_max_s  = (q_ext_s >= MAX_V);
    assign at_zero_s = (q_ext_s == {(WIDTH+1){1'b0}});
    assign tc        = ((dir_s == DIR_UP) && (q_ext_s == MAX_V)) || ((dir_s == DIR_DOWN) && at_zero_s);

    // Next count and boundary detection; load takes priority and never flags a boundary
    always_comb begin
        q_next       = q;
        boundary_hit = 1'b0;
        if (load) begin
            if (ld_ext_s >= MOD_V) begin
                q_next = MAX_V[WIDTH-1:0];
            end else begin
                q_next = load_val;
            end
        end else if (en) begin
            case (dir_s)
                DIR_UP: begin
                    if (at_max_s) begin
                        boundary_hit = 1'b1;
                        q_next       = (SATURATE == CNT_SAT) ? q : {WIDTH{1'b0}};
                    end else begin
                        q_next = inc_s[WIDTH-1:0];
                    end
                end
                DIR_DOWN: begin
                    if (at_zero_s) begin
                        boundary_hit = 1'b1;
                        q_next       = (SATURATE == CNT_SAT) ? q : MAX_V[WIDTH-1:0];
                    end else begin
                        q_next = dec_s[WIDTH-1:0];
                    end
                end
                default: begin
                    q_next       = q;
                    boundary_hit = 1'b0;
                end
            endcase
        end else begin
            q_next       = q;
            boundary_hit = 1'b0;
        end
    end

endmodule : counter_next_logic

// File: rtl/mod_updown_counter.sv
// Parametrised modulo-N up/down counter with load, wrap/saturate mode, event pulse and sticky overflow.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             evt,
    output logic             ovf
);

    generate
        if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             evt_q;
    logic             evt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] q_next_s;
    logic             boundary_hit_s;

    counter_next_logic #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .q            (q_q),
        .up           (up),
        .en           (en),
        .load         (load),
        .load_val     (load_val),
        .q_next       (q_next_s),
        .boundary_hit (boundary_hit_s),
        .tc           (tc)
    );

    // Next-state: a boundary event sets ovf even when a clear arrives on the same edge
    always_comb begin
        q_d   = q_next_s;
        evt_d = boundary_hit_s;
        ovf_d = boundary_hit_s | (ovf_q & ~clr_ovf);
    end

    // State registers with synchronous reset overriding load and count
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= {WIDTH{1'b0}};
            evt_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            evt_q <= evt_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign evt = evt_q;
    assign ovf = ovf_q;

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// Directed table-driven bench: wrap instance (MODULUS=10) and saturate instance (MODULUS=10).
module tb_mod_updown_counter;

    typedef struct {
        logic       reset;
        logic       en;
        logic       up;
        logic       load;
        logic       clr;
        logic [3:0] lv;
        logic [3:0] eq;
        logic       eevt;
        logic       eovf;
        logic       etc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       a_reset = 1'b0, a_en = 1'b0, a_up = 1'b0, a_load = 1'b0, a_clr = 1'b0;
    logic [3:0] a_lv = 4'd0;
    logic [3:0] a_q;
    logic       a_tc, a_evt, a_ovf;
    logic       b_reset = 1'b0, b_en = 1'b0, b_up = 1'b0, b_load = 1'b0, b_clr = 1'b0;
    logic [3:0] b_lv = 4'd0;
    logic [3:0] b_q;
    logic       b_tc, b_evt, b_ovf;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(a_reset), .en(a_en), .up(a_up), .load(a_load), .load_val(a_lv),
        .clr_ovf(a_clr), .q(a_q), .tc(a_tc), .evt(a_evt), .ovf(a_ovf)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(b_reset), .en(b_en), .up(b_up), .load(b_load), .load_val(b_lv),
        .clr_ovf(b_clr), .q(b_q), .tc(b_tc), .evt(b_evt), .ovf(b_ovf)
    );

    function automatic void add(input logic r, input logic e, input logic u, input logic l,
                                input logic c, input logic [3:0] lv, input logic [3:0] eq,
                                input logic ee, input logic eo, input logic et);
        vec_t v;
        v.reset = r; v.en = e; v.up = u; v.load = l; v.clr = c; v.lv = lv;
        v.eq = eq; v.eevt = ee; v.eovf = eo; v.etc = et;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step_b(input int idx, input logic r, input logic e, input logic u, input logic l,
                          input logic c, input logic [3:0] lv, input logic [3:0] eq,
                          input logic ee, input logic eo, input logic et);
        @(negedge clk);
        b_reset = r; b_en = e; b_up = u; b_load = l; b_clr = c; b_lv = lv;
        @(posedge clk);
        #1;
        chk("sat_q",   idx, b_q, eq);
        chk("sat_evt", idx, {3'b000, b_evt}, {3'b000, ee});
        chk("sat_ovf", idx, {3'b000, b_ovf}, {3'b000, eo});
        chk("sat_tc",  idx, {3'b000, b_tc},  {3'b000, et});
    endtask

    initial begin
        // Reset two cycles, then count up through a full wrap
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'(k), 1'b0, 1'b0, (k == 9));
        end
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0);
        // Load wins over enable; out-of-range load clamps
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7,  4'd7, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd12, 4'd9, 1'b0, 1'b1, 1'b1);
        // Clear collides with wrap: set wins; then plain clear
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        // Down from zero wraps to 9
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0);
        // Hold with en=0 while up toggles, then one decrement
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd5, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            add(1'b0, 1'b0, k[0], 1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1, 1'b0);
        end
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b1, 1'b0);
        // Reset beats a simultaneous load
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd6, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            a_reset = vecs[i].reset; a_en = vecs[i].en; a_up = vecs[i].up;
            a_load = vecs[i].load; a_clr = vecs[i].clr; a_lv = vecs[i].lv;
            @(posedge clk);
            #1;
            chk("wrap_q",   i, a_q, vecs[i].eq);
            chk("wrap_evt", i, {3'b000, a_evt}, {3'b000, vecs[i].eevt});
            chk("wrap_ovf", i, {3'b000, a_ovf}, {3'b000, vecs[i].eovf});
            chk("wrap_tc",  i, {3'b000, a_tc},  {3'b000, vecs[i].etc});
        end

        // Saturating instance: repeated hold at zero, then at the top
        step_b(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1);
        step_b(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b1, 1'b1);
        step_b(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b1, 1'b1);
        step_b(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b1, 1'b1);
        step_b(4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd1, 1'b0, 1'b1, 1'b0);
        step_b(5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd12, 4'd9, 1'b0, 1'b1, 1'b1);
        step_b(6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd9, 1'b1, 1'b1, 1'b1);
        step_b(7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  4'd9, 1'b1, 1'b1, 1'b1);
        step_b(8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd9, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mod_updown_counter
